// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Pipelined RV32I/RV64I integer execution unit. Operands come in from the
// reservation station. ALU, branch and jump results are computed and tagged
// with their ROB id. Results are queued in an output FIFO and handed to the
// CDB/ROB through a valid/ready handshake.
//
// Parameters:
//   XLEN      datapath width (32 or 64)
//   ROB_W     ROB tag width
//   STAGES    execute latency in cycles (1..4)
//   OUT_DEPTH output FIFO depth (>= 1; use >= STAGES+1 for full throughput)
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rdy                   global enable; when low every register holds
//   flush                 drop all in-flight and buffered results
//   in_valid / in_ready   issue handshake
//   in_rob_id, in_opcode  tag and op code (OP_* encoding below)
//   in_rs1, in_rs2, in_imm, in_pc   operands
//   out_valid / out_ready result handshake
//   out_rob_id, out_res, out_is_br, out_is_jump, out_jump_pc   head result
//
// Optional build macro ALU_MISPRED_EN adds in_pred_taken, in_pred_pc and
// out_mispred (the prediction check for branches and JALR).
//
// Timing: an op accepted on the edge that ends cycle T goes through STAGES-1
// pipeline registers and is then written into the FIFO. It is at the head in
// cycle T+STAGES.
// -----------------------------------------------------------------------------

`ifndef OP_ADD
`define OP_ADD   6'd1
`define OP_SUB   6'd2
`define OP_SLL   6'd3
`define OP_SLT   6'd4
`define OP_SLTU  6'd5
`define OP_XOR   6'd6
`define OP_SRL   6'd7
`define OP_SRA   6'd8
`define OP_OR    6'd9
`define OP_AND   6'd10
`define OP_ADDI  6'd11
`define OP_SLTI  6'd12
`define OP_SLTIU 6'd13
`define OP_XORI  6'd14
`define OP_ORI   6'd15
`define OP_ANDI  6'd16
`define OP_SLLI  6'd17
`define OP_SRLI  6'd18
`define OP_SRAI  6'd19
`define OP_LUI   6'd20
`define OP_AUIPC 6'd21
`define OP_JAL   6'd22
`define OP_JALR  6'd23
`define OP_BEQ   6'd24
`define OP_BNE   6'd25
`define OP_BLT   6'd26
`define OP_BGE   6'd27
`define OP_BLTU  6'd28
`define OP_BGEU  6'd29
`endif

module alu_pipe #(
  parameter int XLEN      = 32,
  parameter int ROB_W     = 4,
  parameter int STAGES    = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROB_W-1:0] in_rob_id,
  input  logic [5:0]       in_opcode,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
`ifdef ALU_MISPRED_EN
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_pred_pc,
  output logic             out_mispred,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROB_W-1:0] out_rob_id,
  output logic [XLEN-1:0]  out_res,
  output logic             out_is_br,
  output logic             out_is_jump,
  output logic [XLEN-1:0]  out_jump_pc
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int PN    = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + STAGES + 1);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("alu_pipe: XLEN must be 32 or 64");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("alu_pipe: STAGES must be in 1..4");
    end
    if (OUT_DEPTH < 1) begin : g_bad_depth
      $error("alu_pipe: OUT_DEPTH must be at least 1");
    end
  endgenerate

  typedef struct packed {
    logic [ROB_W-1:0] rob_id;
    logic [XLEN-1:0]  res;
    logic             is_br;
    logic             is_jump;
    logic [XLEN-1:0]  jump_pc;
`ifdef ALU_MISPRED_EN
    logic             mispred;
`endif
  } res_t;

  // ---------------------------------------------------------------------------
  // Issue handshake and credit check
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_count;
  logic [PN-1:0]    pipe_vld;
  logic             accept;
  logic             pop;
  logic             push_vld;
  res_t             push_data;

  // The credit check counts only entries already held. A pop in this cycle
  // does not free a slot until the next cycle.
  assign in_ready = rdy && !flush && !rst &&
                    ((inflight + fifo_count) < CNT_W'(OUT_DEPTH));
  assign accept   = in_valid && in_ready;
  assign out_valid = (fifo_count != '0);
  assign pop       = rdy && !flush && out_valid && out_ready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < PN; i++) begin
      inflight = inflight + CNT_W'(pipe_vld[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Execute (combinational, on the issuing operands)
  // ---------------------------------------------------------------------------
  res_t            ex;
  logic            is_imm_op;
  logic [XLEN-1:0] op_b;
  logic [SH_W-1:0] shamt;
  logic            lt_s;
  logic            lt_u;
  logic            eq;
  logic            is_branch;
  logic            take;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jr_tgt;

  always_comb begin
    is_imm_op = (in_opcode >= `OP_ADDI) && (in_opcode <= `OP_SRAI);
    op_b      = is_imm_op ? in_imm : in_rs2;
    shamt     = op_b[SH_W-1:0];
    lt_s      = $signed(in_rs1) < $signed(op_b);
    lt_u      = in_rs1 < op_b;
    eq        = in_rs1 == op_b;
    pc4       = in_pc + XLEN'(4);
    br_tgt    = in_pc + in_imm;
    jr_tgt    = (in_rs1 + in_imm) & ~XLEN'(1);
    is_branch = 1'b0;
    take      = 1'b0;

    ex        = '0;
    ex.rob_id = in_rob_id;

    case (in_opcode)
      `OP_ADD,  `OP_ADDI:  ex.res = in_rs1 + op_b;
      `OP_SUB:             ex.res = in_rs1 - in_rs2;
      `OP_SLL,  `OP_SLLI:  ex.res = in_rs1 << shamt;
      `OP_SLT,  `OP_SLTI:  ex.res = XLEN'(lt_s);
      `OP_SLTU, `OP_SLTIU: ex.res = XLEN'(lt_u);
      `OP_XOR,  `OP_XORI:  ex.res = in_rs1 ^ op_b;
      `OP_SRL,  `OP_SRLI:  ex.res = in_rs1 >> shamt;
      `OP_SRA,  `OP_SRAI:  ex.res = XLEN'($signed(in_rs1) >>> shamt);
      `OP_OR,   `OP_ORI:   ex.res = in_rs1 | op_b;
      `OP_AND,  `OP_ANDI:  ex.res = in_rs1 & op_b;
      `OP_LUI:             ex.res = in_imm;
      `OP_AUIPC:           ex.res = in_pc + in_imm;
      // The frontend already redirected for JAL, so only the link is written.
      `OP_JAL:             ex.res = pc4;
      `OP_JALR: begin
        ex.res     = pc4;
        ex.is_br   = 1'b1;
        ex.is_jump = 1'b1;
        ex.jump_pc = jr_tgt;
`ifdef ALU_MISPRED_EN
        ex.mispred = !(in_pred_taken && (jr_tgt == in_pred_pc));
`endif
      end
      `OP_BEQ:  begin is_branch = 1'b1; take = eq;    end
      `OP_BNE:  begin is_branch = 1'b1; take = !eq;   end
      `OP_BLT:  begin is_branch = 1'b1; take = lt_s;  end
      `OP_BGE:  begin is_branch = 1'b1; take = !lt_s; end
      `OP_BLTU: begin is_branch = 1'b1; take = lt_u;  end
      `OP_BGEU: begin is_branch = 1'b1; take = !lt_u; end
      default: ;
    endcase

    if (is_branch) begin
      ex.is_br   = 1'b1;
      ex.is_jump = take;
      ex.jump_pc = take ? br_tgt : pc4;
`ifdef ALU_MISPRED_EN
      ex.mispred = take ^ in_pred_taken;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Latency pipeline: STAGES-1 registers. The FIFO write is the last stage.
  // ---------------------------------------------------------------------------
  res_t pipe_q [PN];

  generate
    if (STAGES == 1) begin : g_nopipe
      assign pipe_vld  = '0;
      assign pipe_q[0] = '0;
      assign push_vld  = accept;
      assign push_data = ex;
    end else begin : g_pipe
      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_vld <= '0;
        end else if (rdy) begin
          if (flush) begin
            pipe_vld <= '0;
          end else begin
            pipe_vld[0] <= accept;
            for (int i = 1; i < PN; i++) begin
              pipe_vld[i] <= pipe_vld[i-1];
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rdy) begin
          pipe_q[0] <= ex;
          for (int i = 1; i < PN; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end

      assign push_vld  = pipe_vld[PN-1];
      assign push_data = pipe_q[PN-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  res_t             mem [OUT_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] last_ptr;
  logic [PTR_W-1:0] disp_ptr;
  logic             do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit gating means a push never finds the FIFO full without a pop.
  assign do_push = rdy && !flush && push_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        // Keep rd_ptr so the head slot, and the stale outputs, do not move.
        wr_ptr     <= rd_ptr;
        fifo_count <= '0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= push_data;
          wr_ptr      <= ptr_inc(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        fifo_count <= fifo_count + CNT_W'(do_push) - CNT_W'(pop);
      end
    end
  end

  // When the FIFO drains, keep showing the slot that was last at the head so
  // the outputs hold instead of exposing an older entry.
  assign disp_ptr = out_valid ? rd_ptr : last_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_ptr <= '0;
    end else begin
      last_ptr <= disp_ptr;
    end
  end

  assign out_rob_id  = mem[disp_ptr].rob_id;
  assign out_res     = mem[disp_ptr].res;
  assign out_is_br   = mem[disp_ptr].is_br;
  assign out_is_jump = mem[disp_ptr].is_jump;
  assign out_jump_pc = mem[disp_ptr].jump_pc;
`ifdef ALU_MISPRED_EN
  assign out_mispred = mem[disp_ptr].mispred;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  localparam logic [5:0] OP_ADD = 6'd1,  OP_SUB = 6'd2,  OP_SLL = 6'd3,  OP_SLT = 6'd4;
  localparam logic [5:0] OP_SLTU = 6'd5, OP_XOR = 6'd6,  OP_SRL = 6'd7,  OP_SRA = 6'd8;
  localparam logic [5:0] OP_OR = 6'd9,   OP_AND = 6'd10, OP_ADDI = 6'd11, OP_SLTIU = 6'd13;
  localparam logic [5:0] OP_SRAI = 6'd19, OP_LUI = 6'd20, OP_AUIPC = 6'd21, OP_JAL = 6'd22;
  localparam logic [5:0] OP_JALR = 6'd23, OP_BEQ = 6'd24, OP_BNE = 6'd25, OP_BLT = 6'd26;
  localparam logic [5:0] OP_BGE = 6'd27,  OP_BLTU = 6'd28, OP_BGEU = 6'd29, OP_BAD = 6'd63;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_rob_id, out_rob_id;
  logic [5:0]  in_opcode;
  logic [31:0] in_rs1, in_rs2, in_imm, in_pc, out_res, out_jump_pc;
  logic        out_is_br, out_is_jump;
`ifdef ALU_MISPRED_EN
  logic        in_pred_taken = 1'b0;
  logic [31:0] in_pred_pc = '0;
  logic        out_mispred;
`endif

  alu_pipe #(.XLEN(32), .ROB_W(4), .STAGES(2), .OUT_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_rob_id(in_rob_id),
    .in_opcode(in_opcode), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_pc(in_pc),
`ifdef ALU_MISPRED_EN
    .in_pred_taken(in_pred_taken), .in_pred_pc(in_pred_pc), .out_mispred(out_mispred),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_rob_id(out_rob_id),
    .out_res(out_res), .out_is_br(out_is_br), .out_is_jump(out_is_jump),
    .out_jump_pc(out_jump_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] rs1, rs2, imm, pc;
    logic [3:0]  rob;
    logic [31:0] res;
    logic        br, jmp;
    logic [31:0] jpc;
  } vec_t;

  typedef struct packed {
    logic [3:0]  rob;
    logic [31:0] res;
    logic        br;
    logic        jmp;
    logic [31:0] jpc;
  } out_t;

  vec_t vecs[$];
  out_t got[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result the consumer actually takes.
  always @(negedge clk) begin
    if (!rst && rdy && !flush && out_valid && out_ready)
      got.push_back('{out_rob_id, out_res, out_is_br, out_is_jump, out_jump_pc});
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic add_vec(input logic [5:0] op, input logic [31:0] rs1, rs2, imm, pc,
                         input logic [3:0] rob, input logic [31:0] res,
                         input logic br, jmp, input logic [31:0] jpc);
    vec_t v;
    v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc;
    v.rob = rob; v.res = res; v.br = br; v.jmp = jmp; v.jpc = jpc;
    vecs.push_back(v);
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] rs1, rs2, imm, pc,
                       input logic [3:0] rob);
    bit ok = 0;
    in_valid = 1; in_opcode = op; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_pc = pc; in_rob_id = rob;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL issue_timeout: in_ready stayed 0 for tag %0d", rob);
    end
    step();
    in_valid = 0;
  endtask

  task automatic wait_got(input int n);
    for (int i = 0; i < 40 && got.size() < n; i++) step();
  endtask

  task automatic expect_out(input string name, input out_t exp);
    out_t a;
    if (got.size() == 0) begin
      n_chk++;
      $display("FAIL %s: no result popped, expected tag %0d", name, exp.rob);
    end else begin
      a = got.pop_front();
      check(name, 128'(a), 128'(exp));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_res;
    int c0, nacc;
    bit acc;

    // Directed vector table: op, rs1, rs2, imm, pc, tag -> res, is_br, is_jump, jump_pc
    add_vec(OP_ADD,   32'd5,        32'd7,        32'd0,        32'h0,     4'd0, 32'd12,       0, 0, 32'h0);
    add_vec(OP_SUB,   32'd5,        32'd7,        32'd0,        32'h0,     4'd1, 32'hFFFFFFFE, 0, 0, 32'h0);
    add_vec(OP_SLL,   32'd1,        32'h23,       32'd0,        32'h0,     4'd2, 32'd8,        0, 0, 32'h0);
    add_vec(OP_SLT,   32'hFFFFFFFF, 32'd1,        32'd0,        32'h0,     4'd3, 32'd1,        0, 0, 32'h0);
    add_vec(OP_SLTU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'h0,     4'd4, 32'd0,        0, 0, 32'h0);
    add_vec(OP_XOR,   32'hF0F0,     32'hFF00,     32'd0,        32'h0,     4'd5, 32'h0FF0,     0, 0, 32'h0);
    add_vec(OP_SRL,   32'h80000000, 32'd4,        32'd0,        32'h0,     4'd6, 32'h08000000, 0, 0, 32'h0);
    add_vec(OP_SRA,   32'h80000000, 32'h21,       32'd0,        32'h0,     4'd7, 32'hC0000000, 0, 0, 32'h0);
    add_vec(OP_OR,    32'hF0,       32'h0F,       32'd0,        32'h0,     4'd8, 32'hFF,       0, 0, 32'h0);
    add_vec(OP_AND,   32'hF0,       32'h3C,       32'd0,        32'h0,     4'd9, 32'h30,       0, 0, 32'h0);
    add_vec(OP_ADDI,  32'hFFFFFFFF, 32'd9,        32'd1,        32'h0,     4'd10, 32'd0,       0, 0, 32'h0);
    add_vec(OP_SLTIU, 32'd0,        32'd0,        32'hFFFFFFFF, 32'h0,     4'd11, 32'd1,       0, 0, 32'h0);
    add_vec(OP_SRAI,  32'hFFFFFF00, 32'd0,        32'd4,        32'h0,     4'd12, 32'hFFFFFFF0, 0, 0, 32'h0);
    add_vec(OP_LUI,   32'd7,        32'd0,        32'h12345000, 32'h0,     4'd13, 32'h12345000, 0, 0, 32'h0);
    add_vec(OP_AUIPC, 32'd0,        32'd0,        32'h2000,     32'h1000,  4'd14, 32'h3000,    0, 0, 32'h0);
    add_vec(OP_JAL,   32'd0,        32'd0,        32'h80,       32'h200,   4'd15, 32'h204,     0, 0, 32'h0);
    add_vec(OP_JALR,  32'h1003,     32'd0,        32'd2,        32'h40,    4'd0, 32'h44,       1, 1, 32'h1004);
    add_vec(OP_BLT,   32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,   4'd1, 32'd0,        1, 1, 32'h120);
    add_vec(OP_BLTU,  32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,   4'd2, 32'd0,        1, 0, 32'h104);
    add_vec(OP_BEQ,   32'd3,        32'd3,        32'hFFFFFFF0, 32'h300,   4'd3, 32'd0,        1, 1, 32'h2F0);
    add_vec(OP_BNE,   32'd3,        32'd3,        32'h40,       32'h10,    4'd4, 32'd0,        1, 0, 32'h14);
    add_vec(OP_BGE,   32'd1,        32'd1,        32'h8,        32'h20,    4'd5, 32'd0,        1, 1, 32'h28);
    add_vec(OP_BGEU,  32'd1,        32'hFFFFFFFF, 32'h8,        32'h50,    4'd6, 32'd0,        1, 0, 32'h54);
    add_vec(OP_BAD,   32'd5,        32'd6,        32'd7,        32'h60,    4'd9, 32'd0,        0, 0, 32'h0);

    rst = 1; rdy = 1; flush = 0; in_valid = 0; out_ready = 1;
    in_opcode = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_pc = '0; in_rob_id = '0;

    // Reset state
    step(); step();
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_head", {out_rob_id, out_res, out_is_br, out_is_jump, out_jump_pc}, 0);
    step();
    rst = 0;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);
    step();

    // Latency: ADD accepted at T0 is at the head in T2
    in_valid = 1; in_opcode = OP_ADD; in_rs1 = 5; in_rs2 = 7; in_rob_id = 3;
    step();
    in_valid = 0;
    @(negedge clk);
    check("latency_T1_valid", out_valid, 0);
    step();
    @(negedge clk);
    check("latency_T2_valid", out_valid, 1);
    check("latency_T2_head", {out_rob_id, out_res}, {4'd3, 32'd12});
    step();
    expect_out("latency_pop", '{4'd3, 32'd12, 1'b0, 1'b0, 32'h0});

    // Back-to-back ADDI, one per cycle
    c0 = cyc;
    for (int k = 0; k < 6; k++) issue(OP_ADDI, 32'(k * 10), 32'd0, 32'd1, 32'h0, 4'(k + 4));
    check("b2b_cycles", cyc - c0, 6);
    wait_got(6);
    for (int k = 0; k < 6; k++)
      expect_out("b2b_order", '{4'(k + 4), 32'(k * 10 + 1), 1'b0, 1'b0, 32'h0});

    // Backpressure: credits run out after 4 accepts
    out_ready = 0;
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_opcode = OP_ADDI; in_rs1 = 32'(nacc * 256); in_imm = 5;
      in_rob_id = 4'(8 + nacc);
      @(negedge clk);
      acc = in_ready;
      step();
      if (acc) nacc++;
    end
    in_valid = 0;
    check("credit_accepts", nacc, 4);
    @(negedge clk);
    check("credit_full_ready", in_ready, 0);
    step();
    out_ready = 1;
    @(negedge clk);
    check("no_pop_bypass", in_ready, 0);
    step();
    @(negedge clk);
    check("ready_after_pop", in_ready, 1);
    wait_got(4);
    for (int k = 0; k < 4; k++)
      expect_out("drain_order", '{4'(8 + k), 32'(k * 256 + 5), 1'b0, 1'b0, 32'h0});

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].pc, vecs[i].rob);
      wait_got(1);
      expect_out($sformatf("vec%0d", i),
                 '{vecs[i].rob, vecs[i].res, vecs[i].br, vecs[i].jmp, vecs[i].jpc});
    end

    // Flush with work in flight and buffered, plus in_valid in the flush cycle
    out_ready = 0;
    for (int k = 1; k <= 4; k++) issue(OP_ADD, 32'(k), 32'd100, 32'd0, 32'h0, 4'(k));
    in_valid = 1; in_opcode = OP_ADD; in_rs1 = 50; in_rs2 = 50; in_rob_id = 5;
    flush = 1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    step();
    flush = 0; in_valid = 0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    out_ready = 1;
    for (int i = 0; i < 8; i++) step();
    check("flush_no_results", got.size(), 0);
    issue(OP_ADD, 32'd1, 32'd2, 32'd0, 32'h0, 4'd6);
    wait_got(1);
    expect_out("after_flush", '{4'd6, 32'd3, 1'b0, 1'b0, 32'h0});

    // rdy low freezes everything
    out_ready = 0;
    for (int k = 0; k < 3; k++) issue(OP_ADD, 32'(k), 32'd1000, 32'd0, 32'h0, 4'(7 + k));
    step(); step();
    in_valid = 1; in_opcode = OP_ADD; in_rs1 = 3; in_rs2 = 1000; in_rob_id = 10;
    rdy = 0; out_ready = 1;
    @(negedge clk);
    hold_res = out_res;
    for (int i = 0; i < 3; i++) begin
      check("rdy0_in_ready", in_ready, 0);
      check("rdy0_head", {out_valid, out_rob_id, out_res, hold_res}, {1'b1, 4'd7, 32'd1000, 32'd1000});
      step();
      @(negedge clk);
    end
    check("rdy0_no_pop", got.size(), 0);
    step();
    rdy = 1;
    step();
    in_valid = 0;
    wait_got(4);
    for (int k = 0; k < 4; k++)
      expect_out("rdy_resume", '{4'(7 + k), 32'(1000 + k), 1'b0, 1'b0, 32'h0});

    // Reset mid-stream
    out_ready = 0;
    issue(OP_JALR, 32'h1003, 32'd0, 32'd2, 32'h40, 4'd12);
    issue(OP_ADD, 32'd1, 32'd1, 32'd0, 32'h0, 4'd13);
    step(); step();
    @(negedge clk);
    check("pre_reset_head", {out_valid, out_rob_id, out_is_br, out_is_jump, out_jump_pc},
          {1'b1, 4'd12, 1'b1, 1'b1, 32'h1004});
    step();
    rst = 1;
    @(negedge clk);
    check("reset_cycle_in_ready", in_ready, 0);
    step();
    @(negedge clk);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_head", {out_rob_id, out_res, out_is_br, out_is_jump, out_jump_pc}, 0);
    step();
    rst = 0; out_ready = 1;
    for (int i = 0; i < 6; i++) step();
    check("midreset_no_results", got.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
